// File: rtl/wb_trace_buffer.sv
// Writeback trace capture: timestamps register/memory write events during a
// bounded window after reset and queues them for a valid/ready consumer.
module wb_trace_buffer #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int MEM_ADDR_WIDTH = 12,
    parameter int DEPTH          = 16,
    parameter int CYCLE_WIDTH    = 16,
    parameter int NUM_CYCLES     = 255,
    parameter int CAPTURE_MEM    = 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      rwe,
    input  logic [REG_ADDR_WIDTH-1:0] rd,
    input  logic [DATA_WIDTH-1:0]     rData,
    input  logic                      mwe,
    input  logic [MEM_ADDR_WIDTH-1:0] memAddr,
    input  logic [DATA_WIDTH-1:0]     memDataIn,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_kind,
    output logic [CYCLE_WIDTH-1:0]    out_cycle,
    output logic [MEM_ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      overflow,
    output logic [15:0]               drop_count,
    output logic                      done
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 1 + CYCLE_WIDTH + MEM_ADDR_WIDTH + DATA_WIDTH;
    localparam int WW = $clog2(NUM_CYCLES + 1);

    typedef enum logic {S_CAPTURE, S_DONE} state_e;

    state_e                 state_q, state_d;
    logic [CYCLE_WIDTH-1:0] cyc_q, cyc_d;
    logic [WW-1:0]          win_q, win_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic [15:0]            drop_q, drop_d;
    logic [EW-1:0]          head_q, head_d;

    logic [EW-1:0]          mem_q [DEPTH];

    logic                   capturing;
    logic                   reg_ev;
    logic                   mem_ev;
    logic                   pop;
    logic [CW:0]            free;
    logic [1:0]             n_ev;
    logic [1:0]             n_push;
    logic [1:0]             n_drop;
    logic [CW-1:0]          remain;
    logic [PW-1:0]          wr1_ptr;
    logic [16:0]            drop_sum;
    logic [EW-1:0]          reg_entry;
    logic [EW-1:0]          mem_entry;
    logic [EW-1:0]          push0_entry;
    logic [DEPTH-1:0]       we0;
    logic [DEPTH-1:0]       we1;

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        win_d       = win_q;
        capturing   = (state_q == S_CAPTURE);
        reg_ev      = capturing && rwe && (rd != '0);
        mem_ev      = capturing && (CAPTURE_MEM != 0) && mwe;
        pop         = (count_q != '0) && out_ready;
        // A same-cycle pop frees a slot, so a full FIFO being drained still takes one push.
        free        = (CW+1)'(DEPTH) - {1'b0, count_q} + (CW+1)'(pop);
        n_ev        = {1'b0, reg_ev} + {1'b0, mem_ev};
        n_push      = (free >= (CW+1)'(n_ev)) ? n_ev : free[1:0];
        n_drop      = n_ev - n_push;
        reg_entry   = {1'b0, cyc_q, MEM_ADDR_WIDTH'(rd), rData};
        mem_entry   = {1'b1, cyc_q, memAddr, memDataIn};
        // Register event goes first, and wins the only free slot when space is short.
        push0_entry = reg_ev ? reg_entry : mem_entry;
        wr1_ptr     = wr_ptr_q + PW'(1);
        wr_ptr_d    = wr_ptr_q + PW'(n_push);
        rd_ptr_d    = rd_ptr_q + PW'(pop);
        remain      = count_q - CW'(pop);
        count_d     = remain + CW'(n_push);
        drop_sum    = {1'b0, drop_q} + 17'(n_drop);
        drop_d      = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        overflow_d  = overflow_q || (n_drop != 2'd0);

        head_d = head_q;
        if (remain != '0) begin
            head_d = mem_q[rd_ptr_d];
        end else if (n_push != 2'd0) begin
            head_d = push0_entry;
        end

        if (capturing) begin
            cyc_d = cyc_q + CYCLE_WIDTH'(1);
            win_d = win_q + WW'(1);
            if (win_q == WW'(NUM_CYCLES - 1)) begin
                state_d = S_DONE;
            end
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
        assign we0[gi] = (n_push != 2'd0) && (wr_ptr_q == PW'(gi));
        assign we1[gi] = (n_push == 2'd2) && (wr1_ptr == PW'(gi));
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (we0[i]) begin
                mem_q[i] <= push0_entry;
            end else if (we1[i]) begin
                mem_q[i] <= mem_entry;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= S_CAPTURE;
            cyc_q      <= '0;
            win_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            head_q     <= '0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            win_q      <= win_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            head_q     <= head_d;
        end
    end

    assign out_valid  = (count_q != '0);
    assign out_data   = head_q[DATA_WIDTH-1:0];
    assign out_addr   = head_q[DATA_WIDTH +: MEM_ADDR_WIDTH];
    assign out_cycle  = head_q[DATA_WIDTH+MEM_ADDR_WIDTH +: CYCLE_WIDTH];
    assign out_kind   = head_q[EW-1];
    assign count      = count_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;
    assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: table-driven single events, overflow,
// drain-while-full, window closure and asynchronous reset with pending entries.
module tb_wb_trace_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT 1: DEPTH=4, long window, memory capture on
    logic        rst_n, rwe, mwe, ready;
    logic [4:0]  rd;
    logic [31:0] rdata, mdata;
    logic [11:0] maddr;
    logic        valid, kind, ovf, done;
    logic [15:0] cyc, drops;
    logic [11:0] addr;
    logic [31:0] data;
    logic [2:0]  cnt;

    // DUT 2: DEPTH=8, 8-cycle window, register capture only
    logic        rst2_n, rwe2, mwe2, ready2;
    logic [4:0]  rd2;
    logic [31:0] rdata2, mdata2;
    logic [11:0] maddr2;
    logic        valid2, kind2, ovf2, done2;
    logic [15:0] cyc2, drops2;
    logic [11:0] addr2;
    logic [31:0] data2;
    logic [3:0]  cnt2;

    wb_trace_buffer #(
        .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .MEM_ADDR_WIDTH(12), .DEPTH(4),
        .CYCLE_WIDTH(16), .NUM_CYCLES(255), .CAPTURE_MEM(1)
    ) dut (
        .clock(clk), .reset(rst_n), .rwe(rwe), .rd(rd), .rData(rdata),
        .mwe(mwe), .memAddr(maddr), .memDataIn(mdata),
        .out_valid(valid), .out_ready(ready), .out_kind(kind), .out_cycle(cyc),
        .out_addr(addr), .out_data(data), .count(cnt), .overflow(ovf),
        .drop_count(drops), .done(done)
    );

    wb_trace_buffer #(
        .DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .MEM_ADDR_WIDTH(12), .DEPTH(8),
        .CYCLE_WIDTH(16), .NUM_CYCLES(8), .CAPTURE_MEM(0)
    ) dut2 (
        .clock(clk), .reset(rst2_n), .rwe(rwe2), .rd(rd2), .rData(rdata2),
        .mwe(mwe2), .memAddr(maddr2), .memDataIn(mdata2),
        .out_valid(valid2), .out_ready(ready2), .out_kind(kind2), .out_cycle(cyc2),
        .out_addr(addr2), .out_data(data2), .count(cnt2), .overflow(ovf2),
        .drop_count(drops2), .done(done2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int tb_cyc;
    logic [63:0] sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] ent(input logic k, input logic [15:0] c,
                                        input logic [11:0] a, input logic [31:0] d);
        return {3'b000, k, c, a, d};
    endfunction

    // posedges since reset release on DUT 1; the value seen after an edge is the
    // stamp the next edge will apply
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cyc <= 0;
        else        tb_cyc <= tb_cyc + 1;
    end

    // scoreboard: compare the head whenever the DUT hands over an entry
    always @(negedge clk) begin
        if (rst_n && valid && ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_entry: got kind=%0d cycle=%0d addr=0x%0h data=0x%0h, expected none",
                         kind, cyc, addr, data);
            end else begin
                $display("pop kind=%0d cycle=%0d addr=0x%0h data=0x%0h", kind, cyc, addr, data);
                check("head_entry", {3'b000, kind, cyc, addr, data}, sb.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          at;
        logic        rwe;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        mwe;
        logic [11:0] maddr;
        logic [31:0] mdata;
        logic        exp_reg;
        logic        exp_mem;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int guard;
        logic [15:0] first_stamp;

        vecs[0] = '{5,  1'b1, 5'd3,  32'hFFFF_FFF9, 1'b0, 12'h000, 32'h0,          1'b1, 1'b0};
        vecs[1] = '{10, 1'b1, 5'd4,  32'd1,         1'b1, 12'h100, 32'd2,          1'b1, 1'b1};
        vecs[2] = '{15, 1'b1, 5'd0,  32'd42,        1'b0, 12'h000, 32'h0,          1'b0, 1'b0};
        vecs[3] = '{20, 1'b0, 5'd9,  32'd77,        1'b1, 12'hFFF, 32'hDEAD_BEEF,  1'b0, 1'b1};
        vecs[4] = '{25, 1'b1, 5'd31, 32'h1234_5678, 1'b0, 12'h000, 32'h0,          1'b1, 1'b0};
        vecs[5] = '{30, 1'b1, 5'd0,  32'd55,        1'b1, 12'h005, 32'd9,          1'b0, 1'b1};
        vecs[6] = '{35, 1'b0, 5'd6,  32'd66,        1'b0, 12'h006, 32'd10,         1'b0, 1'b0};

        rst_n = 1'b0; rwe = 1'b0; rd = '0; rdata = '0; mwe = 1'b0; maddr = '0; mdata = '0; ready = 1'b1;
        rst2_n = 1'b0; rwe2 = 1'b0; rd2 = '0; rdata2 = '0; mwe2 = 1'b0; maddr2 = '0; mdata2 = '0; ready2 = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(valid), 64'd0);
        check("rst_count", 64'(cnt), 64'd0);
        check("rst_overflow", 64'(ovf), 64'd0);
        check("rst_drops", 64'(drops), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_head", {3'b000, kind, cyc, addr, data}, 64'd0);
        rst_n = 1'b1;

        // table-driven single-cycle events, drained with out_ready=1
        for (int i = 0; i < 7; i++) begin
            guard = 0;
            while (tb_cyc < vecs[i].at && guard < 1000) begin
                @(posedge clk); #1;
                guard++;
            end
            check($sformatf("vec%0d_start_cycle", i), 64'(tb_cyc), 64'(vecs[i].at));
            rwe = vecs[i].rwe; rd = vecs[i].rd; rdata = vecs[i].rdata;
            mwe = vecs[i].mwe; maddr = vecs[i].maddr; mdata = vecs[i].mdata;
            if (vecs[i].exp_reg) sb.push_back(ent(1'b0, 16'(tb_cyc), 12'(vecs[i].rd), vecs[i].rdata));
            if (vecs[i].exp_mem) sb.push_back(ent(1'b1, 16'(tb_cyc), vecs[i].maddr, vecs[i].mdata));
            @(posedge clk); #1;
            rwe = 1'b0; mwe = 1'b0;
            repeat (3) begin @(posedge clk); #1; end
            check($sformatf("vec%0d_count", i), 64'(cnt), 64'd0);
            check($sformatf("vec%0d_overflow", i), 64'(ovf), 64'd0);
            check($sformatf("vec%0d_pending", i), 64'(sb.size()), 64'd0);
        end

        // overflow: six writes into a 4-deep FIFO with no consumer
        @(posedge clk); #1;
        rst_n = 1'b0;
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        ready = 1'b0;
        first_stamp = 16'(tb_cyc);
        for (int i = 1; i <= 6; i++) begin
            rwe = 1'b1; rd = 5'(i); rdata = 32'(100 + i);
            if (i <= 4) sb.push_back(ent(1'b0, 16'(tb_cyc), 12'(i), 32'(100 + i)));
            @(posedge clk); #1;
        end
        rwe = 1'b0;
        check("ovf_count", 64'(cnt), 64'd4);
        check("ovf_flag", 64'(ovf), 64'd1);
        check("ovf_drops", 64'(drops), 64'd2);
        @(posedge clk); #1;
        check("stall_head", {3'b000, kind, cyc, addr, data}, ent(1'b0, first_stamp, 12'd1, 32'd101));

        // full FIFO with a pop and a push on the same edge
        ready = 1'b1;
        rwe = 1'b1; rd = 5'd7; rdata = 32'd200;
        sb.push_back(ent(1'b0, 16'(tb_cyc), 12'd7, 32'd200));
        @(posedge clk); #1;
        rwe = 1'b0;
        check("full_push_count", 64'(cnt), 64'd4);
        check("full_push_drops", 64'(drops), 64'd2);
        guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("drain_pending", 64'(sb.size()), 64'd0);
        check("drain_valid", 64'(valid), 64'd0);
        check("drain_count", 64'(cnt), 64'd0);

        // refill past capacity, then reset with entries pending
        ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rwe = 1'b1; rd = 5'(10 + i); rdata = 32'(300 + i);
            @(posedge clk); #1;
        end
        rwe = 1'b0;
        check("refill_count", 64'(cnt), 64'd4);
        check("refill_drops", 64'(drops), 64'd4);
        rst_n = 1'b0;
        #1;
        check("midrst_count", 64'(cnt), 64'd0);
        check("midrst_valid", 64'(valid), 64'd0);
        check("midrst_overflow", 64'(ovf), 64'd0);
        check("midrst_drops", 64'(drops), 64'd0);

        // capture window of 8 cycles on DUT 2; mwe is ignored with memory capture off
        @(posedge clk); #1;
        rst2_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rwe2 = 1'b1; mwe2 = 1'b1; maddr2 = 12'(i); mdata2 = 32'(i);
            rd2 = 5'((i % 31) + 1); rdata2 = 32'(1000 + i);
            @(posedge clk); #1;
            if (i == 6) check("win_done_before", 64'(done2), 64'd0);
            if (i == 7) check("win_done_after", 64'(done2), 64'd1);
        end
        rwe2 = 1'b0; mwe2 = 1'b0;
        check("win_count", 64'(cnt2), 64'd8);
        check("win_overflow", 64'(ovf2), 64'd0);
        check("win_drops", 64'(drops2), 64'd0);
        ready2 = 1'b1;
        for (int j = 0; j < 5; j++) begin
            $display("pop2 kind=%0d cycle=%0d addr=0x%0h data=0x%0h", kind2, cyc2, addr2, data2);
            check($sformatf("win_entry%0d", j), {3'b000, valid2, kind2, cyc2, addr2, data2},
                  {3'b000, 1'b1, 1'b0, 16'(j), 12'(j + 1), 32'(1000 + j)});
            @(posedge clk); #1;
        end
        check("win_partial_count", 64'(cnt2), 64'd3);
        rst2_n = 1'b0;
        #1;
        check("win_rst_count", 64'(cnt2), 64'd0);
        check("win_rst_done", 64'(done2), 64'd0);
        check("win_rst_valid", 64'(valid2), 64'd0);
        check("win_rst_overflow", 64'(ovf2), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
- Synthesizable writeback trace capture for the processor; sits beside the regfile/RAM, snooping register-write and memory-write strobes.
- Timestamps each qualifying event with a free-running cycle count and queues it in a parametrised FIFO.
- A valid/ready port drains the FIFO, from a UART/debug bridge on FPGA or from a bench in sim.
- Replaces per-cycle printf tracing with a bounded, on-chip run window.

Parameters:
DATA_WIDTH, 32, width of register/memory data.
REG_ADDR_WIDTH, 5, register index width.
MEM_ADDR_WIDTH, 12, captured memory address width.
DEPTH, 16, FIFO entries; power of two, >= 2.
CYCLE_WIDTH, 16, timestamp width.
NUM_CYCLES, 255, capture window length in cycles after reset release.
CAPTURE_MEM, 1, 1 = also capture memory writes; 0 = register writes only.

Ports:
clock  in  1  system clock, all state on posedge.
reset  in  1  asynchronous, active-low reset.
rwe  in  1  regfile write enable.
rd  in  REG_ADDR_WIDTH  regfile write index.
rData  in  DATA_WIDTH  regfile write data.
mwe  in  1  data-memory write enable.
memAddr  in  MEM_ADDR_WIDTH  data-memory address.
memDataIn  in  DATA_WIDTH  data-memory write data.
out_valid  out  1  head entry available.
out_ready  in  1  consumer accepts head entry.
out_kind  out  1  0 = register write, 1 = memory write.
out_cycle  out  CYCLE_WIDTH  cycle stamp of event.
out_addr  out  MEM_ADDR_WIDTH  rd (zero-extended) or memAddr.
out_data  out  DATA_WIDTH  written value.
count  out  clog2(DEPTH)+1  occupancy.
overflow  out  1  sticky: at least one event dropped.
drop_count  out  16  number of dropped events, saturating at 0xFFFF.
done  out  1  capture window closed.

Behaviour:
- Reset (reset=0, async) clears all outputs: out_valid, out_kind, out_cycle, out_addr, out_data, count, overflow, drop_count, done all 0. Pointers, cycle counter and FIFO contents are invalidated.
- States: CAPTURE then DONE.
  - After reset release, cycle counter starts at 0 on the first posedge and increments every posedge in CAPTURE.
  - When counter == NUM_CYCLES-1 at a posedge, events at that edge are still captured, then the state moves to DONE and done=1.
  - DONE persists until reset. No captures occur in DONE; draining continues.
- Cycle counter wraps modulo 2^CYCLE_WIDTH and is independent of the window length.
- Register event qualifies when rwe=1 and rd!=0. Memory event qualifies when CAPTURE_MEM=1 and mwe=1.
- Events are sampled at posedge with the current counter value as the stamp. They are visible on out_* no earlier than the next cycle (1-cycle latency, registered head).
- Up to two pushes per cycle; the register event is ordered before the memory event.
- Overflow:
  - If free slots are fewer than qualifying events, the register event takes priority; each event that does not fit is dropped.
  - Each drop sets overflow and increments drop_count by 1 per dropped event (saturating).
- Free-slot calculation counts a pop occurring in the same cycle. A full FIFO with out_valid & out_ready still accepts one push.
- Pop: out_valid & out_ready at posedge advances the head. out_* stay stable while out_valid=1 and out_ready=0.
- Empty: out_valid=0; out_* hold their last values (don't-care).
- count is always equal to pushes minus pops. Never exceeds DEPTH.
- Reset mid-operation discards all queued entries immediately.

Test Plan:
1. Reset low, then release. Stimulus: rwe=1, rd=3, rData=-7 at cycle 5; out_ready=1. Required: one entry with kind 0, cycle 5, addr 3, data 0xFFFFFFF9; count returns to 0.
2. rwe=1, rd=0, rData=42. Required: no entry, count=0, overflow=0.
3. CAPTURE_MEM=1, same cycle 10: rwe/rd=4/data=1 and mwe/memAddr=0x100/data=2. Required: head is register entry (cycle 10), then memory entry (cycle 10, addr 0x100, data 2).
4. DEPTH=4, out_ready=0, six register writes on consecutive cycles. Required: count=4, overflow=1, drop_count=2. Draining yields the first four in order; then out_valid=0.
5. Full FIFO, out_ready=1, and a new write in the same cycle. Required: push accepted, count stays 4, drop_count unchanged.
6. NUM_CYCLES=8, writes every cycle. Required: entries stamped 0..7 only; done=1 from cycle 8; asserting reset while entries are pending clears count, done and overflow immediately.
